// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light sensor conditioning block:
// per-channel state encoding and the run-counter width.
package tl_pkg;

  localparam int RUN_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_QUAL = 2'b01,
    ST_OCC  = 2'b10,
    ST_GAP  = 2'b11
  } tl_state_e;

  // Traffic is reported present while occupied or while bridging a gap.
  function automatic logic state_active(input tl_state_e s);
    return (s == ST_OCC) || (s == ST_GAP);
  endfunction

endpackage

// File: rtl/tl_sensor_chan.sv
// One street's sensor channel: 2-flop synchroniser, debounce/gap-bridging
// FSM with run counter, and a saturating arrival counter.
module tl_sensor_chan
  import tl_pkg::*;
#(
  parameter int DEB_CYCLES  = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw,
  input  logic             cnt_clr,
  output logic             t,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [RUN_W-1:0] DEB_L   = RUN_W'(DEB_CYCLES);
  localparam logic [RUN_W-1:0] HOLD_L  = RUN_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             sync1_q, sync2_q;
  tl_state_e        state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             t_q, t_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             arrive;

  // Bring the asynchronous loop signal into the clk domain; sync2_q is the
  // only copy the FSM looks at.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Next-state logic: qualify DEB_CYCLES consecutive highs before asserting,
  // tolerate up to HOLD_CYCLES-1 consecutive lows before releasing.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    arrive  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sync2_q) begin
          if (DEB_CYCLES == 1) begin
            state_d = ST_OCC;
            run_d   = '0;
            arrive  = 1'b1;
          end else begin
            state_d = ST_QUAL;
            run_d   = RUN_ONE;
          end
        end
      end
      ST_QUAL: begin
        if (!sync2_q) begin
          state_d = ST_IDLE;
          run_d   = '0;
        end else if (run_q + RUN_ONE == DEB_L) begin
          state_d = ST_OCC;
          run_d   = '0;
          arrive  = 1'b1;
        end else begin
          run_d = run_q + RUN_ONE;
        end
      end
      ST_OCC: begin
        if (!sync2_q) begin
          if (HOLD_CYCLES == 1) begin
            state_d = ST_IDLE;
            run_d   = '0;
          end else begin
            state_d = ST_GAP;
            run_d   = RUN_ONE;
          end
        end
      end
      ST_GAP: begin
        if (sync2_q) begin
          // Gap absorbed: traffic output never drops.
          state_d = ST_OCC;
          run_d   = '0;
        end else if (run_q + RUN_ONE == HOLD_L) begin
          state_d = ST_IDLE;
          run_d   = '0;
        end else begin
          run_d = run_q + RUN_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        run_d   = '0;
      end
    endcase
  end

  // Output is registered from the next state so it tracks the FSM exactly.
  always_comb begin
    t_d = state_active(state_d);
  end

  // Arrival counter: clear and count combine, so a clear coinciding with an
  // arrival leaves a count of one; otherwise saturate at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = arrive ? CNT_ONE : '0;
    end else if (arrive && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Register FSM state, run counter, traffic output and arrival count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      run_q   <= '0;
      t_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
    end
  end

  assign t   = t_q;
  assign cnt = cnt_q;

endmodule

// File: rtl/tl_sensor_cond.sv
// Sensor conditioning for both streets of the traffic-light controller:
// two independent channels sharing clock, reset and the counter clear.
module tl_sensor_cond
  import tl_pkg::*;
#(
  parameter int DEB_CYCLES  = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sa_raw,
  input  logic             sb_raw,
  input  logic             cnt_clr,
  output logic             Ta,
  output logic             Tb,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  tl_sensor_chan #(
    .DEB_CYCLES (DEB_CYCLES),
    .HOLD_CYCLES(HOLD_CYCLES),
    .CNT_W      (CNT_W)
  ) u_chan_a (
    .clk    (clk),
    .reset  (reset),
    .raw    (sa_raw),
    .cnt_clr(cnt_clr),
    .t      (Ta),
    .cnt    (cnt_a)
  );

  tl_sensor_chan #(
    .DEB_CYCLES (DEB_CYCLES),
    .HOLD_CYCLES(HOLD_CYCLES),
    .CNT_W      (CNT_W)
  ) u_chan_b (
    .clk    (clk),
    .reset  (reset),
    .raw    (sb_raw),
    .cnt_clr(cnt_clr),
    .t      (Tb),
    .cnt    (cnt_b)
  );

endmodule
